// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmit FSM states, register map and default frame geometry.
package spart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_t;

    localparam logic [1:0] IOADDR_TXDATA = 2'b00;

    localparam int unsigned DEFAULT_DATA_W     = 8;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/spart_bit_timer.sv
// Counts baud enables and pulses bit_end on the OVERSAMPLE-th enable after clr.
module spart_bit_timer
    import spart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic baud,
    input  logic clr,
    output logic bit_end
);

    localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] tick_q, tick_d;

    always_comb begin
        bit_end = baud & ~clr & (tick_q == LAST_TICK);
        tick_d  = tick_q;
        if (clr) begin
            tick_d = '0;
        end else if (baud) begin
            tick_d = (tick_q == LAST_TICK) ? '0 : tick_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/spart_tx_control.sv
// SPART transmitter: one-deep holding buffer feeding an 8N1 serialiser paced by the baud enable.
module spart_tx_control
    import spart_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    input  logic [DATA_W-1:0] data_in,
    output logic              txd,
    output logic              tbr,
    output logic              tx_busy
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tbr_q, tbr_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              wr;
    logic              bit_end;
    logic              load_shift;

    assign wr = iocs & ~iorw & (ioaddr == IOADDR_TXDATA);

    // Timer is held clear while idle so the start bit always counts a full set of enables.
    spart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .baud    (baud),
        .clr     (state_q == StIdle),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            tbr_q     <= 1'b1;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tbr_q     <= tbr_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!tbr_q) state_d = StStart;
            StStart: if (bit_end) state_d = StData;
            StData:  if (bit_end && (bit_cnt_q == LAST_BIT)) state_d = StStop;
            StStop:  if (bit_end) state_d = tbr_q ? StIdle : StStart;
            default: state_d = StIdle;
        endcase
    end

    // A full buffer is moved to the shifter from idle, or at the stop-bit end for gapless frames.
    assign load_shift = ~tbr_q & ((state_q == StIdle) | ((state_q == StStop) & bit_end));

    always_comb begin
        hold_d    = hold_q;
        tbr_d     = tbr_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;

        if (load_shift) begin
            shift_d = hold_q;
            tbr_d   = 1'b1;
        end else if ((state_q == StData) && bit_end) begin
            shift_d   = DATA_W'({1'b1, shift_q} >> 1);
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end

        if ((state_q == StStart) && bit_end) begin
            bit_cnt_d = '0;
        end

        if (wr && tbr_q) begin
            hold_d = data_in;
            tbr_d  = 1'b0;
        end

        unique case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    assign txd     = txd_q;
    assign tbr     = tbr_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_spart_tx_control.sv
// Bench for spart_tx_control: frame-level reference model plus directed and random sequences.
module tb_spart_tx_control;

    localparam int unsigned DW = 8;
    localparam int unsigned OS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          baud = 1'b0;
    logic          iocs = 1'b0;
    logic          iorw = 1'b1;
    logic [1:0]    ioaddr = 2'b00;
    logic [DW-1:0] data_in = '0;
    logic          txd;
    logic          tbr;
    logic          tx_busy;

    int checks = 0;
    int failures = 0;
    int baud_div = 4;

    spart_tx_control #(
        .DATA_W     (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .baud    (baud),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .data_in (data_in),
        .txd     (txd),
        .tbr     (tbr),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    initial begin : baud_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            baud = (cnt == 0);
            if (cnt + 1 >= baud_div) cnt = 0;
            else cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes awaiting transmission, and the frame currently on the line
    // measured in baud enables since its start.
    logic [7:0] pend_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] rx_q[$];
    bit         in_frame = 1'b0;
    int         pulses = 0;
    logic [7:0] cur = '0;
    logic [7:0] rx_byte = '0;

    always @(posedge clk) begin : monitor
        bit   tbr_pre;
        bit   wr_now;
        int   seg;
        logic exp_txd;
        #1;
        if (!rst_n) begin
            pend_q.delete();
            in_frame = 1'b0;
            pulses   = 0;
            check("rst_txd", txd, 1);
            check("rst_tbr", tbr, 1);
            check("rst_busy", tx_busy, 0);
        end else begin
            tbr_pre = (pend_q.size() == 0);
            wr_now  = iocs && !iorw && (ioaddr == 2'b00);
            if (in_frame && baud) begin
                pulses++;
                seg = pulses / OS;
                if ((pulses % OS == OS / 2) && seg >= 1 && seg <= 8) rx_byte[seg-1] = txd;
                if (pulses == 10 * OS) begin
                    in_frame = 1'b0;
                    sent_q.push_back(cur);
                    rx_q.push_back(rx_byte);
                end
            end
            if (!in_frame && pend_q.size() != 0) begin
                cur      = pend_q.pop_front();
                in_frame = 1'b1;
                pulses   = 0;
            end
            if (wr_now && tbr_pre) pend_q.push_back(data_in);

            exp_txd = 1'b1;
            if (in_frame) begin
                seg = pulses / OS;
                if (seg == 0) exp_txd = 1'b0;
                else if (seg <= 8) exp_txd = cur[seg-1];
            end
            check("txd", txd, exp_txd);
            check("tbr", tbr, pend_q.size() == 0);
            check("tx_busy", tx_busy, in_frame);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic cs, input logic rw, input logic [1:0] addr,
                             input logic [7:0] d);
        @(negedge clk);
        iocs = cs; iorw = rw; ioaddr = addr; data_in = d;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((in_frame || pend_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_bound", n < budget, 1);
    endtask

    task automatic wait_tbr(input int budget);
        int n;
        n = 0;
        while (tbr !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_tbr_bound", n < budget, 1);
    endtask

    typedef struct {
        logic       cs;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] d;
        logic       exp_tbr1;
        logic       exp_txd2;
    } vec_t;

    vec_t vecs[7];

    initial begin : main
        int runs[$];
        int len;
        int n;
        int gaps;
        int base;
        logic prev;

        vecs[0] = '{1'b1, 1'b0, 2'b01, 8'h11, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 2'b00, 8'h22, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 2'b00, 8'h33, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 2'b11, 8'h44, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 2'b00, 8'hC5, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 2'b10, 8'h66, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b0};

        // Reset, then a long quiet idle period
        #1 rst_n = 1'b0;
        tick(5);
        check("reset_txd", txd, 1);
        check("reset_tbr", tbr, 1);
        check("reset_busy", tx_busy, 0);
        rst_n = 1'b1;
        tick(1000);
        check("idle_txd", txd, 1);
        check("idle_tbr", tbr, 1);
        check("idle_busy", tx_busy, 0);

        // Decode and latency table
        for (int i = 0; i < 7; i++) begin
            wait_idle(5000);
            base = rx_q.size();
            @(negedge clk);
            iocs = vecs[i].cs; iorw = vecs[i].rw; ioaddr = vecs[i].addr; data_in = vecs[i].d;
            @(posedge clk); #1;
            check("vec_tbr1", tbr, vecs[i].exp_tbr1);
            check("vec_busy1", tx_busy, 0);
            @(negedge clk);
            iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
            @(posedge clk); #1;
            check("vec_tbr2", tbr, 1);
            check("vec_txd2", txd, vecs[i].exp_txd2);
            wait_idle(5000);
            check("vec_frames", rx_q.size() - base, vecs[i].exp_tbr1 ? 0 : 1);
            if (!vecs[i].exp_tbr1 && rx_q.size() > base) check("vec_rx", rx_q[base], vecs[i].d);
        end

        // Single 8'h55 frame: every bit toggles, so measure each bit length in clocks
        wait_idle(5000);
        base = rx_q.size();
        bus_write(1'b1, 1'b0, 2'b00, 8'h55);
        n = 0;
        @(posedge clk); #1;
        while (txd !== 1'b0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("h55_start_bound", n < 20, 1);
        len = 1; prev = 1'b0; n = 0;
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (!tx_busy) begin
                runs.push_back(len);
                break;
            end else if (txd !== prev) begin
                runs.push_back(len);
                len = 1;
                prev = txd;
            end else begin
                len++;
            end
        end
        check("h55_bits", runs.size(), 10);
        if (runs.size() == 10) begin
            check("h55_start_len", (runs[0] > 4 * OS - 4) && (runs[0] <= 4 * OS), 1);
            for (int k = 1; k < 10; k++) check("h55_bit_len", runs[k], 4 * OS);
        end
        wait_idle(5000);
        if (rx_q.size() > base) check("h55_rx", rx_q[base], 8'h55);

        // Back-to-back frames with no idle gap
        wait_idle(5000);
        base = rx_q.size();
        bus_write(1'b1, 1'b0, 2'b00, 8'hA3);
        wait_tbr(50);
        bus_write(1'b1, 1'b0, 2'b00, 8'h0F);
        gaps = 0; n = 0;
        while (rx_q.size() < base + 2 && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (!tx_busy && rx_q.size() < base + 2) gaps++;
        end
        check("b2b_bound", n < 5000, 1);
        check("b2b_gaps", gaps, 0);
        if (rx_q.size() >= base + 2) begin
            check("b2b_rx0", rx_q[base], 8'hA3);
            check("b2b_rx1", rx_q[base+1], 8'h0F);
        end

        // Overrun: third write while the buffer is still full is dropped
        wait_idle(5000);
        base = rx_q.size();
        bus_write(1'b1, 1'b0, 2'b00, 8'h12);
        wait_tbr(50);
        bus_write(1'b1, 1'b0, 2'b00, 8'h34);
        bus_write(1'b1, 1'b0, 2'b00, 8'h56);
        wait_idle(5000);
        check("ovr_frames", rx_q.size() - base, 2);
        if (rx_q.size() >= base + 2) begin
            check("ovr_rx0", rx_q[base], 8'h12);
            check("ovr_rx1", rx_q[base+1], 8'h34);
        end

        // Asynchronous reset during data bit 3 of 8'hF7 (that bit is 0)
        wait_idle(5000);
        bus_write(1'b1, 1'b0, 2'b00, 8'hF7);
        n = 0;
        while (!(in_frame && pulses >= 4 * OS + 2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_bound", n < 2000, 1);
        check("mid_pre_txd", txd, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_tbr", tbr, 1);
        check("mid_rst_busy", tx_busy, 0);
        tick(3);
        rst_n = 1'b1;
        base = rx_q.size();
        tick(400);
        check("post_rst_frames", rx_q.size(), base);
        check("post_rst_busy", tx_busy, 0);

        // Random bus traffic at a faster baud rate
        baud_div = 2;
        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                bus_write(1'b1, 1'b0, 2'b00, 8'($urandom));
            end else if (r <= 6) begin
                int kind;
                kind = $urandom_range(0, 2);
                if (kind == 0) bus_write(1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
                else if (kind == 1) bus_write(1'b1, 1'b1, 2'($urandom), 8'($urandom));
                else bus_write(1'b1, 1'b0, 2'($urandom_range(1, 3)), 8'($urandom));
            end else begin
                tick($urandom_range(1, 200));
            end
        end
        wait_idle(10000);
        check("rand_count", rx_q.size(), sent_q.size());
        for (int k = 0; k < rx_q.size() && k < sent_q.size(); k++) begin
            check("rand_rx", rx_q[k], sent_q[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
